// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
// Latency: combinational.
// Backpressure: none.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial add/subtract with LEGv8 N/Z/V/C flags, one bit per cycle LSB first.
// Latency: WIDTH cycles from acceptance to result_valid.
// Backpressure: result held in DONE until result_ready; start_ready only in IDLE.
module serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             subtract,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             cout_q, cout_d;
   logic             start_ready_q, start_ready_d;
   logic             result_valid_q, result_valid_d;

   logic             fa_sum;
   logic             fa_cout;

   // Single adder cell: current LSBs of the operand shift registers plus running carry.
   full_adder u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state, datapath shifting and flag capture.
   always_comb begin
      state_d        = state_q;
      a_d            = a_q;
      b_d            = b_q;
      res_d          = res_q;
      carry_d        = carry_q;
      cnt_d          = cnt_q;
      neg_d          = neg_q;
      zero_d         = zero_q;
      ovf_d          = ovf_q;
      cout_d         = cout_q;

      case (state_q)
         IDLE: begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            if (start_valid) begin
               a_d     = A_in;
               b_d     = subtract ? ~B_in : B_in;
               carry_d = subtract;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               // carry_q here is the carry into the MSB; fa_cout is the carry out of it.
               neg_d   = fa_sum;
               zero_d  = (res_d == '0);
               ovf_d   = carry_q ^ fa_cout;
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      start_ready_d  = (state_d == IDLE);
      result_valid_d = (state_d == DONE);
   end

   // State and datapath registers; synchronous reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         a_q            <= '0;
         b_q            <= '0;
         res_q          <= '0;
         carry_q        <= 1'b0;
         cnt_q          <= '0;
         neg_q          <= 1'b0;
         zero_q         <= 1'b0;
         ovf_q          <= 1'b0;
         cout_q         <= 1'b0;
         start_ready_q  <= 1'b1;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_q            <= a_d;
         b_q            <= b_d;
         res_q          <= res_d;
         carry_q        <= carry_d;
         cnt_q          <= cnt_d;
         neg_q          <= neg_d;
         zero_q         <= zero_d;
         ovf_q          <= ovf_d;
         cout_q         <= cout_d;
         start_ready_q  <= start_ready_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign start_ready  = start_ready_q;
   assign result_valid = result_valid_q;
   assign result       = res_q;
   assign negative     = neg_q;
   assign zero         = zero_q;
   assign overflow     = ovf_q;
   assign carry_out    = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=64.
// Latency: checks result_valid exactly 64 edges after acceptance.
// Backpressure: exercises DONE hold and reset abort.
module tb_serial_adder;

   localparam int WIDTH = 64;

   logic             clk;
   logic             reset_n;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic             subtract;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] result;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .A_in         (A_in),
      .B_in         (B_in),
      .subtract     (subtract),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .negative     (negative),
      .zero         (zero),
      .overflow     (overflow),
      .carry_out    (carry_out)
   );

   // 120-unit period leaves ample settling time for the carry path.
   initial clk = 1'b0;
   always #60 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer an operation at a negedge; it is accepted on the next posedge. Operands are
   // then scrambled to prove they are ignored, and the latency and result are checked.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic [63:0] exp_res, input logic [3:0] exp_nzvc);
      int n;
      A_in        = a;
      B_in        = b;
      subtract    = sub;
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      A_in        = ~a;
      B_in        = {$urandom, $urandom};
      subtract    = ~sub;
      chk({tag, " start_ready in RUN"}, start_ready, 1'b0);
      n = 0;
      while (!result_valid && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, " latency"}, n, WIDTH);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " NZVC"}, {negative, zero, overflow, carry_out}, exp_nzvc);
   endtask

   // Complete the DONE handshake and confirm the return to IDLE.
   task automatic take_result(input string tag);
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, " valid after take"}, result_valid, 1'b0);
      chk({tag, " ready after take"}, start_ready, 1'b1);
   endtask

   initial begin
      bit seen_valid;
      // Reset with a pending start: reset must win and nothing is accepted.
      reset_n      = 1'b0;
      start_valid  = 1'b1;
      result_ready = 1'b0;
      A_in         = 64'd9;
      B_in         = 64'd9;
      subtract     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset start_ready", start_ready, 1'b1);
      chk("reset result_valid", result_valid, 1'b0);
      chk("reset result", result, 64'd0);
      chk("reset NZVC", {negative, zero, overflow, carry_out}, 4'b0000);
      start_valid = 1'b0;
      reset_n     = 1'b1;
      @(posedge clk);
      @(negedge clk);

      run_op("add 1+1", 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000);
      take_result("add 1+1");

      run_op("add max+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010);
      take_result("add max+1");

      run_op("sub 5-5", 64'd5, 64'd5, 1'b1, 64'd0, 4'b0101);
      take_result("sub 5-5");

      run_op("sub 0-1", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
      take_result("sub 0-1");

      run_op("add ff+1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101);
      take_result("add ff+1");

      // Hold off the consumer for 10 cycles while start_valid and operands churn.
      run_op("hold op", 64'h1234, 64'h1111, 1'b0, 64'h2345, 4'b0000);
      start_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         A_in     = {$urandom, $urandom};
         B_in     = {$urandom, $urandom};
         subtract = i[0];
         @(posedge clk);
         @(negedge clk);
         chk("hold result", result, 64'h2345);
         chk("hold NZVC", {negative, zero, overflow, carry_out}, 4'b0000);
         chk("hold start_ready", start_ready, 1'b0);
         chk("hold result_valid", result_valid, 1'b1);
      end
      A_in     = 64'd10;
      B_in     = 64'd3;
      subtract = 1'b1;
      take_result("hold op");
      // start_valid is still high: the next edge is the earliest acceptance.
      run_op("sub 10-3 after hold", 64'd10, 64'd3, 1'b1, 64'd7, 4'b0001);
      take_result("sub 10-3");

      // Abort an operation with a one-edge reset at RUN cycle 30.
      A_in        = 64'd100;
      B_in        = 64'd200;
      subtract    = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (29) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort result_valid", result_valid, 1'b0);
      chk("abort result", result, 64'd0);
      chk("abort start_ready", start_ready, 1'b1);
      seen_valid = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid) seen_valid = 1'b1;
      end
      chk("abort no late result", seen_valid, 1'b0);

      run_op("add 3+4", 64'd3, 64'd4, 1'b0, 64'd7, 4'b0000);
      take_result("add 3+4");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port start_valid, input, 1, meaning a new operation is offered.
REQ-005 SHALL have port start_ready, output, 1, meaning the block can accept an operation.
REQ-006 SHALL have port A_in, input, WIDTH, the first operand.
REQ-007 SHALL have port B_in, input, WIDTH, the second operand.
REQ-008 SHALL have port subtract, input, 1, selecting A-B when 1 and A+B when 0.
REQ-009 SHALL have port result_valid, output, 1, meaning the result and flags are valid.
REQ-010 SHALL have port result_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port result, output, WIDTH, the sum or difference.
REQ-012 SHALL have ports negative, zero, overflow and carry_out, each output, 1, the LEGv8 N/Z/V/C flags.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL assert start_ready only in IDLE.
REQ-015 SHALL accept an operation on a rising edge where start_valid and start_ready are both 1, capturing A_in, B_in and subtract, and entering RUN.
REQ-016 SHALL ignore every change on A_in, B_in and subtract after acceptance, until the next acceptance.
REQ-017 SHALL on acceptance load a carry register with subtract, and load the B shift register with B_in inverted when subtract=1.
REQ-018 SHALL in RUN process exactly one bit per cycle, LSB first, through a single full_adder, registering the sum bit into a result shift register and carry_out into the carry register.
REQ-019 SHALL use a bit counter of $clog2(WIDTH) bits and leave RUN after exactly WIDTH RUN edges.
REQ-020 SHALL give a latency of exactly WIDTH cycles: if acceptance is at edge k, result_valid goes high after edge k+WIDTH.
REQ-021 SHALL set carry_out to the final carry, which for subtraction means no borrow.
REQ-022 SHALL set overflow to the carry into the MSB XOR the final carry.
REQ-023 SHALL set negative to result[WIDTH-1].
REQ-024 SHALL set zero to 1 exactly when result is all zeros.
REQ-025 SHALL hold result and the flags stable, with result_valid=1, in DONE until result_ready=1.
REQ-026 SHALL on the DONE handshake edge return to IDLE and clear result_valid; the earliest next acceptance is on the following edge, with no same-cycle restart.
REQ-027 SHALL keep result_ready without effect outside DONE, and start_valid without effect outside IDLE.
REQ-028 SHALL drive all outputs from registers.

Reset
REQ-029 SHALL on any edge with reset_n=0 enter IDLE, clear the counter, carry register and shift registers, and set result=0, all flags=0, result_valid=0 and start_ready=1 from the next cycle.
REQ-030 SHALL on reset during RUN or DONE abort the operation without producing a result.
REQ-031 SHALL give reset priority over every handshake on the same edge.

Structure
REQ-032 SHALL declare the FSM state enum and the default width constant (64) in the shared package alu_pkg.
REQ-033 SHALL instantiate exactly one full_adder as its only sub-module; the bench clock period SHALL exceed 2x50 time units so the carry path settles within a cycle.

Verification
REQ-034 Scenario: WIDTH=64, add 1+1 -> result=2, N=Z=V=C=0, result_valid high exactly 64 cycles after acceptance.
REQ-035 Scenario: add 0x7FFF_FFFF_FFFF_FFFF+1 -> result=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0.
REQ-036 Scenario: subtract 5-5 -> result=0, Z=1, C=1, N=0, V=0.
REQ-037 Scenario: subtract 0-1 -> result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0, V=0; add 0xFFFF_FFFF_FFFF_FFFF+1 -> result=0, Z=1, C=1.
REQ-038 Scenario: result_ready held low 10 cycles in DONE with start_valid=1 and changing operands -> result and flags unchanged, start_ready=0; after the handshake, the next operation is accepted one cycle later and is correct.
REQ-039 Scenario: reset_n low for one edge at RUN cycle 30 -> IDLE next cycle, result_valid=0, result=0; a following add 3+4 -> 7.
